// File: rtl/lsu_align_pkg.sv
// Shared definitions for the load/store alignment unit: widths, size codes, FSM states.
package lsu_align_pkg;

  localparam int LSU_DWIDTH     = 32;
  localparam int LSU_AWIDTH_MEM = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_CAP  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/lsu_align_if.sv
// EX request, memory port and MEM/WB result signals of the load/store unit.
interface lsu_align_if
  import lsu_align_pkg::*;
#(
  parameter int DWIDTH     = LSU_DWIDTH,
  parameter int AWIDTH_MEM = LSU_AWIDTH_MEM
);
  logic                  ls_i_valid;
  logic                  ls_o_ready;
  logic                  ls_i_we;
  logic [1:0]            ls_i_size;
  logic                  ls_i_unsigned;
  logic [AWIDTH_MEM+1:0] ls_i_addr;
  logic [DWIDTH-1:0]     ls_i_wdata;
  logic [4:0]            ls_i_rd;
  logic                  ls_i_flush;
  logic                  ls_o_ce;
  logic                  ls_o_wr_en;
  logic [AWIDTH_MEM-1:0] ls_o_addr;
  logic [3:0]            ls_o_mask;
  logic [DWIDTH-1:0]     ls_o_store_data;
  logic [DWIDTH-1:0]     ls_i_load_data;
  logic                  ls_o_valid;
  logic                  ls_i_ready;
  logic [DWIDTH-1:0]     ls_o_data;
  logic [4:0]            ls_o_rd;
  logic                  ls_o_regwrite;
  logic                  ls_o_fault;

  modport slave (
    input  ls_i_valid, ls_i_we, ls_i_size, ls_i_unsigned, ls_i_addr, ls_i_wdata,
           ls_i_rd, ls_i_flush, ls_i_load_data, ls_i_ready,
    output ls_o_ready, ls_o_ce, ls_o_wr_en, ls_o_addr, ls_o_mask, ls_o_store_data,
           ls_o_valid, ls_o_data, ls_o_rd, ls_o_regwrite, ls_o_fault
  );

  modport master (
    output ls_i_valid, ls_i_we, ls_i_size, ls_i_unsigned, ls_i_addr, ls_i_wdata,
           ls_i_rd, ls_i_flush, ls_i_load_data, ls_i_ready,
    input  ls_o_ready, ls_o_ce, ls_o_wr_en, ls_o_addr, ls_o_mask, ls_o_store_data,
           ls_o_valid, ls_o_data, ls_o_rd, ls_o_regwrite, ls_o_fault
  );
endinterface

// File: rtl/lsu_align_load_extend.sv
// Selects the addressed byte/half of a little-endian memory word and sign/zero-extends it.
module load_extend
  import lsu_align_pkg::*;
(
  input  logic [1:0]            lane_i,
  input  size_t                 size_i,
  input  logic                  unsigned_i,
  input  logic [LSU_DWIDTH-1:0] raw_i,
  output logic [LSU_DWIDTH-1:0] result_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? raw_i[31:16] : raw_i[15:0];
    result_o = '0;
    unique case (size_i)
      SZ_BYTE: result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SZ_WORD: result_o = raw_i;
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/lsu_align.sv
// Load/store unit: alignment check, memory request formatting and load result alignment,
// one access in flight through IDLE -> REQ -> CAP -> RESP.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int DWIDTH     = LSU_DWIDTH,
  parameter int AWIDTH_MEM = LSU_AWIDTH_MEM
) (
  input logic        ls_clk,
  input logic        ls_rst,
  lsu_align_if.slave bus
);
  logic [1:0]        lane_d;
  size_t             size_d;
  logic              fault_d;
  logic [3:0]        mask_d;
  logic [DWIDTH-1:0] sdata_d;
  logic              accept;

  state_t                state_q;
  logic                  ready_q;
  logic                  ce_q;
  logic                  we_q;
  logic [AWIDTH_MEM-1:0] addr_q;
  logic [3:0]            mask_q;
  logic [DWIDTH-1:0]     sdata_q;
  logic [1:0]            lane_q;
  size_t                 size_q;
  logic                  uns_q;
  logic                  load_q;
  logic                  fault_q;
  logic                  drop_q;
  logic [4:0]            rd_q;
  logic                  o_valid_q;
  logic [DWIDTH-1:0]     o_data_q;
  logic [4:0]            o_rd_q;
  logic                  o_regwrite_q;
  logic                  o_fault_q;
  logic [DWIDTH-1:0]     ext_data;

  assign lane_d = bus.ls_i_addr[1:0];
  assign size_d = size_t'(bus.ls_i_size);
  assign accept = (state_q == ST_IDLE) && bus.ls_i_valid && !bus.ls_i_flush;

  always_comb begin
    fault_d = 1'b0;
    mask_d  = '0;
    sdata_d = '0;
    unique case (size_d)
      SZ_BYTE: begin
        mask_d  = 4'b0001 << lane_d;
        sdata_d = {4{bus.ls_i_wdata[7:0]}};
      end
      SZ_HALF: begin
        fault_d = lane_d[0];
        mask_d  = 4'b0011 << lane_d;
        sdata_d = {2{bus.ls_i_wdata[15:0]}};
      end
      SZ_WORD: begin
        fault_d = |lane_d;
        mask_d  = 4'b1111;
        sdata_d = bus.ls_i_wdata;
      end
      default: fault_d = 1'b1;
    endcase
    if (fault_d) mask_d = '0;
  end

  load_extend u_load_extend (
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .raw_i      (bus.ls_i_load_data),
    .result_o   (ext_data)
  );

  always_ff @(posedge ls_clk or posedge ls_rst) begin
    if (ls_rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      mask_q       <= '0;
      sdata_q      <= '0;
      lane_q       <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      fault_q      <= 1'b0;
      drop_q       <= 1'b0;
      rd_q         <= '0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_rd_q       <= '0;
      o_regwrite_q <= 1'b0;
      o_fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ce_q    <= !fault_d;
            we_q    <= bus.ls_i_we && !fault_d;
            addr_q  <= bus.ls_i_addr[AWIDTH_MEM+1:2];
            mask_q  <= mask_d;
            sdata_q <= sdata_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= bus.ls_i_unsigned;
            load_q  <= !bus.ls_i_we;
            fault_q <= fault_d;
            rd_q    <= bus.ls_i_rd;
            drop_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          ce_q    <= 1'b0;
          we_q    <= 1'b0;
          mask_q  <= '0;
          drop_q  <= bus.ls_i_flush;
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          // A flush seen in REQ or now drops the result; the memory access has already happened.
          if (drop_q || bus.ls_i_flush) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            o_valid_q    <= 1'b1;
            o_data_q     <= (load_q && !fault_q) ? ext_data : '0;
            o_rd_q       <= rd_q;
            o_regwrite_q <= load_q && !fault_q;
            o_fault_q    <= fault_q;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.ls_i_ready || bus.ls_i_flush) begin
            o_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ls_o_ready      = ready_q;
  assign bus.ls_o_ce         = ce_q;
  assign bus.ls_o_wr_en      = we_q;
  assign bus.ls_o_addr       = addr_q;
  assign bus.ls_o_mask       = mask_q;
  assign bus.ls_o_store_data = sdata_q;
  assign bus.ls_o_valid      = o_valid_q;
  assign bus.ls_o_data       = o_data_q;
  assign bus.ls_o_rd         = o_rd_q;
  assign bus.ls_o_regwrite   = o_regwrite_q;
  assign bus.ls_o_fault      = o_fault_q;
endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural word memory behind the memory port.
module tb_lsu_align;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   ce_cnt = 0;
  int   wr_cnt = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] rdata = '0;

  lsu_align_if #(.DWIDTH(32), .AWIDTH_MEM(10)) bus ();

  lsu_align #(.DWIDTH(32), .AWIDTH_MEM(10)) dut (
    .ls_clk (clk),
    .ls_rst (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory: samples the request on the edge, read data valid right after it.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[3] <= 32'hAABBCCDD;
    end else if (bus.ls_o_ce) begin
      ce_cnt <= ce_cnt + 1;
      if (bus.ls_o_wr_en) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (bus.ls_o_mask[b]) mem[bus.ls_o_addr][8*b +: 8] <= bus.ls_o_store_data[8*b +: 8];
      end
      rdata <= mem[bus.ls_o_addr];
    end
  end
  assign bus.ls_i_load_data = rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    bus.ls_i_valid    = 1'b1;
    bus.ls_i_we       = we;
    bus.ls_i_size     = size;
    bus.ls_i_unsigned = uns;
    bus.ls_i_addr     = addr;
    bus.ls_i_wdata    = wdata;
    bus.ls_i_rd       = rd;
  endtask

  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic exp_ce, input logic [3:0] exp_mask,
                            input logic [31:0] exp_sdata, input logic [31:0] exp_data,
                            input logic exp_fault);
    int ce0;
    int wr0;
    ce0 = ce_cnt;
    wr0 = wr_cnt;
    chk({tag, " ready_pre"}, 32'(bus.ls_o_ready), 32'd1);
    drive(we, size, uns, addr, wdata, rd);
    tick();
    bus.ls_i_valid = 1'b0;
    chk({tag, " E0 ce"}, 32'(bus.ls_o_ce), 32'(exp_ce));
    chk({tag, " E0 wr_en"}, 32'(bus.ls_o_wr_en), 32'(we & exp_ce));
    chk({tag, " E0 ready"}, 32'(bus.ls_o_ready), 32'd0);
    if (exp_ce) begin
      chk({tag, " E0 mask"}, 32'(bus.ls_o_mask), 32'(exp_mask));
      chk({tag, " E0 addr"}, 32'(bus.ls_o_addr), 32'(addr[11:2]));
      if (we) chk({tag, " E0 sdata"}, bus.ls_o_store_data, exp_sdata);
    end
    tick();
    chk({tag, " E1 ce"}, 32'(bus.ls_o_ce), 32'd0);
    chk({tag, " E1 valid"}, 32'(bus.ls_o_valid), 32'd0);
    tick();
    chk({tag, " E2 valid"}, 32'(bus.ls_o_valid), 32'd1);
    chk({tag, " data"}, bus.ls_o_data, exp_data);
    chk({tag, " rd"}, 32'(bus.ls_o_rd), 32'(rd));
    chk({tag, " regwrite"}, 32'(bus.ls_o_regwrite), 32'(!we && !exp_fault));
    chk({tag, " fault"}, 32'(bus.ls_o_fault), 32'(exp_fault));
    chk({tag, " ce_count"}, 32'(ce_cnt - ce0), 32'(exp_ce));
    chk({tag, " wr_count"}, 32'(wr_cnt - wr0), 32'(we & exp_ce));
    bus.ls_i_ready = 1'b1;
    tick();
    bus.ls_i_ready = 1'b0;
    chk({tag, " done valid"}, 32'(bus.ls_o_valid), 32'd0);
    chk({tag, " done ready"}, 32'(bus.ls_o_ready), 32'd1);
  endtask

  initial begin
    bus.ls_i_valid = 1'b0;
    bus.ls_i_we = 1'b0;
    bus.ls_i_size = 2'b00;
    bus.ls_i_unsigned = 1'b0;
    bus.ls_i_addr = '0;
    bus.ls_i_wdata = '0;
    bus.ls_i_rd = '0;
    bus.ls_i_flush = 1'b0;
    bus.ls_i_ready = 1'b0;
    tick();
    chk("rst ready", 32'(bus.ls_o_ready), 32'd1);
    chk("rst valid", 32'(bus.ls_o_valid), 32'd0);
    chk("rst ce", 32'(bus.ls_o_ce), 32'd0);
    chk("rst data", bus.ls_o_data, 32'd0);
    chk("rst fault", 32'(bus.ls_o_fault), 32'd0);
    rst = 1'b0;
    mem_init = 1'b0;
    tick();

    run_access("LB13",  1'b0, 2'b00, 1'b0, 12'd13, 32'h0, 5'd1, 1'b1, 4'b0010, 32'h0, 32'hFFFFFFCC, 1'b0);
    run_access("LBU13", 1'b0, 2'b00, 1'b1, 12'd13, 32'h0, 5'd2, 1'b1, 4'b0010, 32'h0, 32'h000000CC, 1'b0);
    run_access("LH14",  1'b0, 2'b01, 1'b0, 12'd14, 32'h0, 5'd3, 1'b1, 4'b1100, 32'h0, 32'hFFFFAABB, 1'b0);
    run_access("LHU12", 1'b0, 2'b01, 1'b1, 12'd12, 32'h0, 5'd4, 1'b1, 4'b0011, 32'h0, 32'h0000CCDD, 1'b0);
    run_access("LH12",  1'b0, 2'b01, 1'b0, 12'd12, 32'h0, 5'd5, 1'b1, 4'b0011, 32'h0, 32'hFFFFCCDD, 1'b0);
    run_access("LB15",  1'b0, 2'b00, 1'b0, 12'd15, 32'h0, 5'd6, 1'b1, 4'b1000, 32'h0, 32'hFFFFFFAA, 1'b0);
    run_access("SB17",  1'b1, 2'b00, 1'b0, 12'd17, 32'h12345699, 5'd8, 1'b1, 4'b0010, 32'h99999999, 32'h0, 1'b0);
    run_access("LW16",  1'b0, 2'b10, 1'b0, 12'd16, 32'h0, 5'd9, 1'b1, 4'b1111, 32'h0, 32'h00009900, 1'b0);
    run_access("SH22",  1'b1, 2'b01, 1'b0, 12'd22, 32'h0000EEFF, 5'd10, 1'b1, 4'b1100, 32'hEEFFEEFF, 32'h0, 1'b0);
    run_access("LW20",  1'b0, 2'b10, 1'b0, 12'd20, 32'h0, 5'd11, 1'b1, 4'b1111, 32'h0, 32'hEEFF0000, 1'b0);
    run_access("LW6",   1'b0, 2'b10, 1'b0, 12'd6, 32'h0, 5'd12, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    run_access("LH9",   1'b0, 2'b01, 1'b0, 12'd9, 32'h0, 5'd13, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    run_access("SZ11",  1'b0, 2'b11, 1'b0, 12'd8, 32'h0, 5'd14, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    run_access("SW_F",  1'b1, 2'b10, 1'b0, 12'd26, 32'h55555555, 5'd15, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);

    // Back-pressure in RESP, then a request waiting while the result drains.
    drive(1'b0, 2'b10, 1'b0, 12'd12, 32'h0, 5'd7);
    tick();
    bus.ls_i_valid = 1'b0;
    tick();
    tick();
    chk("bp valid", 32'(bus.ls_o_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp hold valid", 32'(bus.ls_o_valid), 32'd1);
      chk("bp hold data", bus.ls_o_data, 32'hAABBCCDD);
      chk("bp hold rd", 32'(bus.ls_o_rd), 32'd7);
      chk("bp hold ready", 32'(bus.ls_o_ready), 32'd0);
    end
    drive(1'b0, 2'b00, 1'b1, 12'd13, 32'h0, 5'd16);
    bus.ls_i_ready = 1'b1;
    tick();
    bus.ls_i_ready = 1'b0;
    chk("bp release valid", 32'(bus.ls_o_valid), 32'd0);
    chk("bp release ready", 32'(bus.ls_o_ready), 32'd1);
    chk("bp release ce", 32'(bus.ls_o_ce), 32'd0);
    tick();
    bus.ls_i_valid = 1'b0;
    chk("bp next accepted", 32'(bus.ls_o_ready), 32'd0);
    chk("bp next ce", 32'(bus.ls_o_ce), 32'd1);
    tick();
    tick();
    chk("bp next valid", 32'(bus.ls_o_valid), 32'd1);
    chk("bp next data", bus.ls_o_data, 32'h000000CC);
    bus.ls_i_ready = 1'b1;
    tick();
    bus.ls_i_ready = 1'b0;

    // Flush in IDLE blocks acceptance.
    drive(1'b0, 2'b10, 1'b0, 12'd12, 32'h0, 5'd17);
    bus.ls_i_flush = 1'b1;
    tick();
    bus.ls_i_valid = 1'b0;
    bus.ls_i_flush = 1'b0;
    chk("idle flush ready", 32'(bus.ls_o_ready), 32'd1);
    chk("idle flush ce", 32'(bus.ls_o_ce), 32'd0);

    // Flush during REQ of a store: the write still lands, no result.
    drive(1'b1, 2'b10, 1'b0, 12'd24, 32'hDEADBEEF, 5'd18);
    tick();
    bus.ls_i_valid = 1'b0;
    chk("flush E0 wr_en", 32'(bus.ls_o_wr_en), 32'd1);
    bus.ls_i_flush = 1'b1;
    tick();
    bus.ls_i_flush = 1'b0;
    chk("flush E1 valid", 32'(bus.ls_o_valid), 32'd0);
    tick();
    chk("flush E2 valid", 32'(bus.ls_o_valid), 32'd0);
    chk("flush E2 ready", 32'(bus.ls_o_ready), 32'd1);
    tick();
    chk("flush E3 valid", 32'(bus.ls_o_valid), 32'd0);
    run_access("LW24", 1'b0, 2'b10, 1'b0, 12'd24, 32'h0, 5'd19, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);

    // Flush while the result waits in RESP.
    drive(1'b0, 2'b00, 1'b1, 12'd13, 32'h0, 5'd20);
    tick();
    bus.ls_i_valid = 1'b0;
    tick();
    tick();
    chk("resp flush pre", 32'(bus.ls_o_valid), 32'd1);
    bus.ls_i_flush = 1'b1;
    tick();
    bus.ls_i_flush = 1'b0;
    chk("resp flush valid", 32'(bus.ls_o_valid), 32'd0);
    chk("resp flush ready", 32'(bus.ls_o_ready), 32'd1);

    // Reset during REQ of a store drops ce/wr_en without waiting for a clock.
    drive(1'b1, 2'b10, 1'b0, 12'd32, 32'h0BADF00D, 5'd21);
    tick();
    bus.ls_i_valid = 1'b0;
    chk("rstreq wr_en pre", 32'(bus.ls_o_wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstreq ce", 32'(bus.ls_o_ce), 32'd0);
    chk("rstreq wr_en", 32'(bus.ls_o_wr_en), 32'd0);
    chk("rstreq ready", 32'(bus.ls_o_ready), 32'd1);
    rst = 1'b0;
    tick();
    chk("rstreq mem untouched", mem[8], 32'h0);

    // Reset during CAP of a store.
    run_access("LB13b", 1'b0, 2'b00, 1'b0, 12'd13, 32'h0, 5'd22, 1'b1, 4'b0010, 32'h0, 32'hFFFFFFCC, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 12'd28, 32'h12345678, 5'd23);
    tick();
    bus.ls_i_valid = 1'b0;
    tick();
    chk("rstcap sdata pre", bus.ls_o_store_data, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    chk("rstcap ready", 32'(bus.ls_o_ready), 32'd1);
    chk("rstcap valid", 32'(bus.ls_o_valid), 32'd0);
    chk("rstcap ce", 32'(bus.ls_o_ce), 32'd0);
    chk("rstcap wr_en", 32'(bus.ls_o_wr_en), 32'd0);
    chk("rstcap addr", 32'(bus.ls_o_addr), 32'd0);
    chk("rstcap mask", 32'(bus.ls_o_mask), 32'd0);
    chk("rstcap sdata", bus.ls_o_store_data, 32'd0);
    chk("rstcap data", bus.ls_o_data, 32'd0);
    chk("rstcap rd", 32'(bus.ls_o_rd), 32'd0);
    chk("rstcap regwrite", 32'(bus.ls_o_regwrite), 32'd0);
    chk("rstcap fault", 32'(bus.ls_o_fault), 32'd0);
    rst = 1'b0;
    tick();
    run_access("LW28", 1'b0, 2'b10, 1'b0, 12'd28, 32'h0, 5'd24, 1'b1, 4'b1111, 32'h0, 32'h12345678, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
